// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: sums ones across LANES unipolar streams over a window of WIN_LEN accepted samples.
// Optional SC_DEC_BIPOLAR_EN: result becomes RES_W+1 bit two's complement (2*ones - LANES*WIN_LEN).
module sc_stream_decoder #(
  parameter int LANES   = 4,
  parameter int WIN_LEN = 64,
  parameter int RES_W   = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_in,
  input  logic [LANES-1:0]        seq,
  output logic                    en_out,
`ifdef SC_DEC_BIPOLAR_EN
  output logic signed [RES_W:0]   result
`else
  output logic [RES_W-1:0]        result
`endif
);

  localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state;
  logic [RES_W-1:0] acc;
  logic [CNT_W-1:0] scnt;
  logic [RES_W-1:0] pop;
  logic [RES_W-1:0] acc_sum;

  function automatic logic [RES_W-1:0] popcount(input logic [LANES-1:0] s);
    logic [RES_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + RES_W'(s[i]);
    end
    return c;
  endfunction

`ifdef SC_DEC_BIPOLAR_EN
  // Modular arithmetic in RES_W+1 bits is exact because |result| <= LANES*WIN_LEN.
  function automatic logic signed [RES_W:0] to_result(input logic [RES_W-1:0] ones);
    logic signed [RES_W:0] dbl;
    dbl = {ones, 1'b0};
    return dbl - (RES_W+1)'(LANES * WIN_LEN);
  endfunction
`else
  function automatic logic [RES_W-1:0] to_result(input logic [RES_W-1:0] ones);
    return ones;
  endfunction
`endif

  always_comb begin
    pop     = popcount(seq);
    acc_sum = ((state == IDLE) ? '0 : acc) + pop;
  end

  // Single-state-register FSM; seq is only observed when en_in is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      scnt   <= '0;
      en_out <= 1'b0;
      result <= '0;
    end else begin
      en_out <= 1'b0;
      if (en_in) begin
        if (state == ACC && scnt == LAST_CNT) begin
          result <= to_result(acc_sum);
          en_out <= 1'b1;
          acc    <= '0;
          scnt   <= '0;
          state  <= IDLE;
        end else begin
          acc    <= acc_sum;
          scnt   <= scnt + CNT_W'(1);
          state  <= ACC;
        end
      end
    end
  end

endmodule
